// File: rtl/ibex_icache_ram_arb_pkg.sv
// Shared types and default geometry for the icache RAM arbiter.
package ibex_icache_ram_arb_pkg;

    localparam int unsigned IC_NUM_WAYS  = 2;
    localparam int unsigned IC_INDEX_W   = 8;
    localparam int unsigned IC_TAG_SIZE  = 22;
    localparam int unsigned IC_LINE_SIZE = 64;

    typedef enum logic {
        IC_RAM_TAG  = 1'b0,
        IC_RAM_DATA = 1'b1
    } ic_ram_sel_e;

    typedef enum logic {
        IC_ARB_IDLE = 1'b0,
        IC_ARB_RESP = 1'b1
    } ic_arb_state_e;

    // Way-select width; at least one bit so a single-way build still has a port.
    function automatic int unsigned ic_way_w(int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/ibex_icache_ram_arb.sv
// Icache tag/data RAM arbiter. The icache owns the RAM banks whenever it
// drives any request; a secondary requester (scrubber / debug backdoor) is
// granted only the idle cycles. Reads return one cycle after the grant.
// Optional starvation monitor: define IBEX_ICACHE_ARB_STARVE_EN.
module ibex_icache_ram_arb
    import ibex_icache_ram_arb_pkg::*;
#(
    parameter int unsigned NumWays   = IC_NUM_WAYS,
    parameter int unsigned IndexW    = IC_INDEX_W,
    parameter int unsigned TagWidth  = IC_TAG_SIZE,
    parameter int unsigned LineWidth = IC_LINE_SIZE,
    parameter int unsigned MaxStall  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    // icache side
    input  logic [NumWays-1:0]                 ic_tag_req_i,
    input  logic                               ic_tag_write_i,
    input  logic [IndexW-1:0]                  ic_tag_addr_i,
    input  logic [TagWidth-1:0]                ic_tag_wdata_i,
    output logic [NumWays-1:0][TagWidth-1:0]   ic_tag_rdata_o,
    input  logic [NumWays-1:0]                 ic_data_req_i,
    input  logic                               ic_data_write_i,
    input  logic [IndexW-1:0]                  ic_data_addr_i,
    input  logic [LineWidth-1:0]               ic_data_wdata_i,
    output logic [NumWays-1:0][LineWidth-1:0]  ic_data_rdata_o,
    // secondary requester
    input  logic                               sec_req_i,
    output logic                               sec_gnt_o,
    input  logic                               sec_write_i,
    input  ic_ram_sel_e                        sec_sel_i,
    input  logic [ic_way_w(NumWays)-1:0]       sec_way_i,
    input  logic [IndexW-1:0]                  sec_addr_i,
    input  logic [LineWidth-1:0]               sec_wdata_i,
    output logic                               sec_rvalid_o,
    output logic [LineWidth-1:0]               sec_rdata_o,
    output logic                               sec_starved_o,
    // RAM banks
    output logic [NumWays-1:0]                 tag_req_o,
    output logic                               tag_write_o,
    output logic [IndexW-1:0]                  tag_addr_o,
    output logic [TagWidth-1:0]                tag_wdata_o,
    input  logic [NumWays-1:0][TagWidth-1:0]   tag_rdata_i,
    output logic [NumWays-1:0]                 data_req_o,
    output logic                               data_write_o,
    output logic [IndexW-1:0]                  data_addr_o,
    output logic [LineWidth-1:0]               data_wdata_o,
    input  logic [NumWays-1:0][LineWidth-1:0]  data_rdata_i
);

    localparam int unsigned WayW = ic_way_w(NumWays);

    logic                ic_busy;
    logic                rd_gnt;
    ic_arb_state_e       state_q, state_d;
    logic [WayW-1:0]     way_p1;
    ic_ram_sel_e         sel_p1;

    assign ic_busy   = (|ic_tag_req_i) | (|ic_data_req_i);
    assign sec_gnt_o = sec_req_i & ~ic_busy;
    assign rd_gnt    = sec_gnt_o & ~sec_write_i;

    // RAM read data goes straight back to the icache; it only samples after its own request.
    assign ic_tag_rdata_o  = tag_rdata_i;
    assign ic_data_rdata_o = data_rdata_i;

    // RAM port steering: icache by default, secondary only on a granted idle cycle.
    always_comb begin
        tag_req_o    = ic_tag_req_i;
        tag_write_o  = ic_tag_write_i;
        tag_addr_o   = ic_tag_addr_i;
        tag_wdata_o  = ic_tag_wdata_i;
        data_req_o   = ic_data_req_i;
        data_write_o = ic_data_write_i;
        data_addr_o  = ic_data_addr_i;
        data_wdata_o = ic_data_wdata_i;
        if (sec_gnt_o) begin
            tag_req_o    = '0;
            data_req_o   = '0;
            tag_write_o  = sec_write_i;
            tag_addr_o   = sec_addr_i;
            tag_wdata_o  = sec_wdata_i[TagWidth-1:0];
            data_write_o = sec_write_i;
            data_addr_o  = sec_addr_i;
            data_wdata_o = sec_wdata_i;
            if (sec_sel_i == IC_RAM_TAG) begin
                tag_req_o[sec_way_i] = 1'b1;
            end else begin
                data_req_o[sec_way_i] = 1'b1;
            end
        end
    end

    // Response FSM: any granted read lands in RESP for exactly the following cycle.
    always_comb begin
        state_d = IC_ARB_IDLE;
        if (rd_gnt) begin
            state_d = IC_ARB_RESP;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IC_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture way/array of a granted read to steer the returning RAM data.
    always_ff @(posedge clk_i) begin
        if (rd_gnt) begin
            way_p1 <= sec_way_i;
            sel_p1 <= sec_sel_i;
        end
    end

    // Response: RAM data of the captured way, tag reads zero-extended; zero outside RESP.
    always_comb begin
        sec_rvalid_o = (state_q == IC_ARB_RESP);
        sec_rdata_o  = '0;
        if (state_q == IC_ARB_RESP) begin
            if (sel_p1 == IC_RAM_TAG) begin
                sec_rdata_o = LineWidth'(tag_rdata_i[way_p1]);
            end else begin
                sec_rdata_o = data_rdata_i[way_p1];
            end
        end
    end

`ifdef IBEX_ICACHE_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(MaxStall + 1);

    logic [CntW-1:0] stall_cnt_q;

    // Count consecutive refused cycles; saturates at MaxStall, clears on grant or request drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (!sec_req_i || sec_gnt_o) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_q != CntW'(MaxStall)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign sec_starved_o = (stall_cnt_q == CntW'(MaxStall));
`else
    logic unused_max_stall;
    assign unused_max_stall = ^MaxStall;
    assign sec_starved_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_icache_ram_arb.sv
// Directed bench for ibex_icache_ram_arb with a behavioural 1-cycle RAM model
// and a scoreboard of expected secondary read responses.
module tb_ibex_icache_ram_arb;
    import ibex_icache_ram_arb_pkg::*;

    localparam int NW    = 2;
    localparam int IW    = 4;
    localparam int TW    = 22;
    localparam int LW    = 64;
    localparam int MS    = 4;
    localparam int DEPTH = 1 << IW;

    logic clk, rst_ni;
    logic [NW-1:0]          ic_tag_req, ic_data_req;
    logic                   ic_tag_write, ic_data_write;
    logic [IW-1:0]          ic_tag_addr, ic_data_addr;
    logic [TW-1:0]          ic_tag_wdata;
    logic [LW-1:0]          ic_data_wdata;
    logic [NW-1:0][TW-1:0]  ic_tag_rdata, tag_rdata;
    logic [NW-1:0][LW-1:0]  ic_data_rdata, data_rdata;
    logic                   sec_req, sec_gnt, sec_write, sec_rvalid, sec_starved;
    ic_ram_sel_e            sec_sel;
    logic [0:0]             sec_way;
    logic [IW-1:0]          sec_addr;
    logic [LW-1:0]          sec_wdata, sec_rdata;
    logic [NW-1:0]          tag_req, data_req;
    logic                   tag_write, data_write;
    logic [IW-1:0]          tag_addr, data_addr;
    logic [TW-1:0]          tag_wdata;
    logic [LW-1:0]          data_wdata;

    ibex_icache_ram_arb #(
        .NumWays(NW), .IndexW(IW), .TagWidth(TW), .LineWidth(LW), .MaxStall(MS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ic_tag_req_i(ic_tag_req), .ic_tag_write_i(ic_tag_write), .ic_tag_addr_i(ic_tag_addr),
        .ic_tag_wdata_i(ic_tag_wdata), .ic_tag_rdata_o(ic_tag_rdata),
        .ic_data_req_i(ic_data_req), .ic_data_write_i(ic_data_write), .ic_data_addr_i(ic_data_addr),
        .ic_data_wdata_i(ic_data_wdata), .ic_data_rdata_o(ic_data_rdata),
        .sec_req_i(sec_req), .sec_gnt_o(sec_gnt), .sec_write_i(sec_write), .sec_sel_i(sec_sel),
        .sec_way_i(sec_way), .sec_addr_i(sec_addr), .sec_wdata_i(sec_wdata),
        .sec_rvalid_o(sec_rvalid), .sec_rdata_o(sec_rdata), .sec_starved_o(sec_starved),
        .tag_req_o(tag_req), .tag_write_o(tag_write), .tag_addr_o(tag_addr),
        .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata),
        .data_req_o(data_req), .data_write_o(data_write), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rdata_i(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM banks, read latency 1.
    logic [TW-1:0] tag_mem  [NW][DEPTH];
    logic [LW-1:0] data_mem [NW][DEPTH];
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (tag_req[w]) begin
                if (tag_write) tag_mem[w][tag_addr] <= tag_wdata;
                else           tag_rdata[w]         <= tag_mem[w][tag_addr];
            end
            if (data_req[w]) begin
                if (data_write) data_mem[w][data_addr] <= data_wdata;
                else            data_rdata[w]          <= data_mem[w][data_addr];
            end
        end
    end

    // Shadow contents, maintained by the bench only.
    logic [TW-1:0] exp_tag  [NW][DEPTH];
    logic [LW-1:0] exp_data [NW][DEPTH];

    typedef struct { logic [LW-1:0] data; int due; } resp_t;
    resp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        cyc++;
    endtask

    // Let combinational outputs settle, then check the response channel against the scoreboard.
    task automatic settle();
        logic exp_v;
        #1;
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        check("rvalid", 64'(sec_rvalid), 64'(exp_v));
        if (exp_v) begin
            check("rdata", sec_rdata, sb_q[0].data);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic drive_ic(input logic [NW-1:0] treq, input logic [NW-1:0] dreq, input logic [IW-1:0] addr);
        ic_tag_req  = treq;
        ic_data_req = dreq;
        ic_tag_addr = addr;
        ic_data_addr = addr;
        ic_tag_write = 1'b0;
        ic_data_write = 1'b0;
    endtask

    task automatic drive_sec(input logic req, input logic wr, input ic_ram_sel_e sel,
                             input logic [0:0] way, input logic [IW-1:0] addr, input logic [LW-1:0] wd);
        sec_req = req; sec_write = wr; sec_sel = sel; sec_way = way; sec_addr = addr; sec_wdata = wd;
    endtask

    task automatic expect_read(input ic_ram_sel_e sel, input logic [0:0] way, input logic [IW-1:0] addr);
        resp_t r;
        r.data = (sel == IC_RAM_TAG) ? LW'(exp_tag[way][addr]) : exp_data[way][addr];
        r.due  = cyc + 1;
        sb_q.push_back(r);
    endtask

    logic exp_starve;

    initial begin
        for (int w = 0; w < NW; w++) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_tag[w][i]  = TW'(32'h100 + w * 32'h40 + i);
                exp_data[w][i] = {32'hA000_0000 + 32'(w << 8) + 32'(i), 32'h5555_0000 + 32'(i * 3)};
            end
        end
        exp_tag[1][5] = 22'h1A5;
        for (int w = 0; w < NW; w++) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[w][i]  = exp_tag[w][i];
                data_mem[w][i] = exp_data[w][i];
            end
        end
        tag_rdata = '0; data_rdata = '0;
        ic_tag_wdata = '0; ic_data_wdata = '0;
        drive_ic('0, '0, '0);
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        rst_ni = 1'b0;

        // Reset state
        begin_cycle(); begin_cycle(); #1;
        check("rst_gnt", 64'(sec_gnt), 64'd0);
        check("rst_rvalid", 64'(sec_rvalid), 64'd0);
        check("rst_rdata", sec_rdata, 64'd0);
        check("rst_starved", 64'(sec_starved), 64'd0);
        rst_ni = 1'b1;

        // 1: single tag read, way1 idx5
        begin_cycle();
        drive_sec(1'b1, 1'b0, IC_RAM_TAG, 1'b1, 4'd5, '0);
        settle();
        check("t1_gnt", 64'(sec_gnt), 64'd1);
        check("t1_tag_req", 64'(tag_req), 64'b10);
        check("t1_data_req", 64'(data_req), 64'b00);
        if (sec_gnt) expect_read(IC_RAM_TAG, 1'b1, 4'd5);
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        settle();
        check("t1_rdata_lit", sec_rdata, 64'h1A5);

        // 2: icache tag reads for 3 cycles, secondary data read held pending
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            drive_ic(2'b01, 2'b00, 4'd9);
            drive_sec(1'b1, 1'b0, IC_RAM_DATA, 1'b0, 4'd2, '0);
            settle();
            check("t2_gnt_blocked", 64'(sec_gnt), 64'd0);
            check("t2_tag_req", 64'(tag_req), 64'b01);
            check("t2_tag_addr", 64'(tag_addr), 64'd9);
            check("t2_data_req", 64'(data_req), 64'b00);
            if (k > 0) check("t2_ic_rdata", 64'(ic_tag_rdata[0]), 64'(exp_tag[0][9]));
        end
        begin_cycle();
        drive_ic(2'b00, 2'b00, 4'd0);
        settle();
        check("t2_gnt_4th", 64'(sec_gnt), 64'd1);
        check("t2_data_req_sec", 64'(data_req), 64'b01);
        check("t2_tag_req_sec", 64'(tag_req), 64'b00);
        check("t2_ic_rdata_kept", 64'(ic_tag_rdata[0]), 64'(exp_tag[0][9]));
        if (sec_gnt) expect_read(IC_RAM_DATA, 1'b0, 4'd2);
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        settle();

        // 3: secondary write data way0 idx7, then icache read of the same line
        begin_cycle();
        drive_sec(1'b1, 1'b1, IC_RAM_DATA, 1'b0, 4'd7, 64'hDEAD_BEEF_0123_4567);
        settle();
        check("t3_gnt", 64'(sec_gnt), 64'd1);
        check("t3_data_write", 64'(data_write), 64'd1);
        check("t3_data_wdata", data_wdata, 64'hDEAD_BEEF_0123_4567);
        exp_data[0][7] = 64'hDEAD_BEEF_0123_4567;
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        drive_ic(2'b00, 2'b01, 4'd7);
        settle();
        begin_cycle();
        drive_ic(2'b00, 2'b00, 4'd0);
        settle();
        check("t3_ic_sees_write", ic_data_rdata[0], exp_data[0][7]);

        // 4: back-to-back data reads way1 idx 1,2,3
        for (int k = 1; k <= 3; k++) begin
            begin_cycle();
            drive_sec(1'b1, 1'b0, IC_RAM_DATA, 1'b1, IW'(k), '0);
            settle();
            check("t4_gnt", 64'(sec_gnt), 64'd1);
            if (sec_gnt) expect_read(IC_RAM_DATA, 1'b1, IW'(k));
        end
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        settle();
        begin_cycle();
        settle();

        // 5: icache data traffic for 6 cycles starves a tag read
        for (int k = 1; k <= 6; k++) begin
            begin_cycle();
            drive_ic(2'b00, 2'b10, 4'd4);
            drive_sec(1'b1, 1'b0, IC_RAM_TAG, 1'b0, 4'd3, '0);
            settle();
`ifdef IBEX_ICACHE_ARB_STARVE_EN
            exp_starve = (k - 1) >= MS;
`else
            exp_starve = 1'b0;
`endif
            check("t5_gnt_blocked", 64'(sec_gnt), 64'd0);
            check("t5_data_req", 64'(data_req), 64'b10);
            check("t5_starved", 64'(sec_starved), 64'(exp_starve));
        end
        begin_cycle();
        drive_ic(2'b00, 2'b00, 4'd0);
        settle();
        check("t5_gnt", 64'(sec_gnt), 64'd1);
`ifdef IBEX_ICACHE_ARB_STARVE_EN
        check("t5_starved_at_gnt", 64'(sec_starved), 64'd1);
`else
        check("t5_starved_at_gnt", 64'(sec_starved), 64'd0);
`endif
        if (sec_gnt) expect_read(IC_RAM_TAG, 1'b0, 4'd3);
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        settle();
        check("t5_starved_cleared", 64'(sec_starved), 64'd0);

        // 6: reset asserted right after a granted read
        begin_cycle();
        drive_sec(1'b1, 1'b0, IC_RAM_TAG, 1'b1, 4'd5, '0);
        settle();
        check("t6_gnt", 64'(sec_gnt), 64'd1);
        #2 rst_ni = 1'b0;
        begin_cycle();
        drive_sec(1'b0, 1'b0, IC_RAM_TAG, 1'b0, '0, '0);
        settle();
        check("t6_rdata_rst", sec_rdata, 64'd0);
        check("t6_starved_rst", 64'(sec_starved), 64'd0);
        rst_ni = 1'b1;
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            settle();
            check("t6_rdata_after", sec_rdata, 64'd0);
        end

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
